// File: rtl/otter_cu_fsm.sv
`default_nettype none
// ============================================================================
// Module   : otter_cu_fsm
// Brief    : OTTER multi-cycle control sequencer (fetch / exec / load WB),
//            with optional between-instruction interrupt entry, enabled by
//            defining OTTER_CU_FSM_INT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module otter_cu_fsm (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [6:0] CU_OPCODE,
  input  logic [2:0] CU_FUNC3,
  input  logic       INTR,
  input  logic       CSR_MIE,
  input  logic       MEM_RDY,
  output logic       PC_WRITE,
  output logic       REG_WRITE,
  output logic       MEM_RDEN1,
  output logic       MEM_RDEN2,
  output logic       MEM_WE2,
  output logic       CSR_WE,
  output logic       INT_TAKEN,
  output logic       MRET_EXEC,
  output logic       RST_OUT,
  output logic [2:0] CU_STATE
);

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_EXEC      = 3'd2,
    ST_WB        = 3'd3,
    ST_INTERRUPT = 3'd4
  } state_t;

  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_OP     = 7'b0110011;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

  state_t r_state;
  state_t w_next;
  logic   w_done;
  logic   w_int_req;

`ifdef OTTER_CU_FSM_INT_EN
  assign w_int_req = INTR & CSR_MIE;
`else
  logic w_unused_int;
  assign w_unused_int = INTR | CSR_MIE;
  assign w_int_req    = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= ST_INIT;
    else        r_state <= w_next;
  end

  always_comb begin
    PC_WRITE  = 1'b0;
    REG_WRITE = 1'b0;
    MEM_RDEN1 = 1'b0;
    MEM_RDEN2 = 1'b0;
    MEM_WE2   = 1'b0;
    CSR_WE    = 1'b0;
    INT_TAKEN = 1'b0;
    MRET_EXEC = 1'b0;
    RST_OUT   = 1'b0;
    w_done    = 1'b0;
    w_next    = ST_INIT;

    case (r_state)
      ST_INIT: begin
        RST_OUT = 1'b1;
        w_next  = ST_FETCH;
      end
      ST_FETCH: begin
        MEM_RDEN1 = 1'b1;
        w_next    = ST_EXEC;
      end
      ST_EXEC: begin
        case (CU_OPCODE)
          c_OP_LUI, c_OP_AUIPC, c_OP_OP, c_OP_IMM, c_OP_JAL, c_OP_JALR: begin
            PC_WRITE  = 1'b1;
            REG_WRITE = 1'b1;
            w_done    = 1'b1;
          end
          c_OP_LOAD: begin
            MEM_RDEN2 = 1'b1;
            PC_WRITE  = 1'b1;
            w_next    = ST_WB;
          end
          // Write enable is held through the whole stall; PC only moves on ready.
          c_OP_STORE: begin
            MEM_WE2  = 1'b1;
            PC_WRITE = MEM_RDY;
            w_done   = MEM_RDY;
            w_next   = ST_EXEC;
          end
          c_OP_SYSTEM: begin
            PC_WRITE = 1'b1;
            w_done   = 1'b1;
            if (CU_FUNC3 == 3'b000) begin
              MRET_EXEC = 1'b1;
            end else begin
              REG_WRITE = 1'b1;
              CSR_WE    = 1'b1;
            end
          end
          default: begin
            PC_WRITE = 1'b1;
            w_done   = 1'b1;
          end
        endcase
      end
      ST_WB: begin
        REG_WRITE = MEM_RDY;
        w_done    = MEM_RDY;
        w_next    = ST_WB;
      end
      ST_INTERRUPT: begin
`ifdef OTTER_CU_FSM_INT_EN
        INT_TAKEN = 1'b1;
`endif
        PC_WRITE  = 1'b1;
        w_next    = ST_FETCH;
      end
      default: w_next = ST_INIT;
    endcase

    // Instruction boundary: the only place an interrupt can be taken.
    if (w_done) w_next = w_int_req ? ST_INTERRUPT : ST_FETCH;
  end

  assign CU_STATE = r_state;

endmodule
`default_nettype wire

// File: tb/tb_otter_cu_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_otter_cu_fsm
// Brief    : Self-checking bench for otter_cu_fsm; an instruction-level model
//            expands each instruction into its expected cycle sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_otter_cu_fsm;

  logic       CLK;
  logic       RST_N;
  logic [6:0] CU_OPCODE;
  logic [2:0] CU_FUNC3;
  logic       INTR;
  logic       CSR_MIE;
  logic       MEM_RDY;
  logic       PC_WRITE, REG_WRITE, MEM_RDEN1, MEM_RDEN2, MEM_WE2;
  logic       CSR_WE, INT_TAKEN, MRET_EXEC, RST_OUT;
  logic [2:0] CU_STATE;

  int n_cmp = 0;
  int n_err = 0;

`ifdef OTTER_CU_FSM_INT_EN
  localparam bit c_INT_EN = 1'b1;
`else
  localparam bit c_INT_EN = 1'b0;
`endif

  // Output vector: pc, reg, rden1, rden2, we2, csr, int, mret, rst
  localparam logic [8:0] c_O_INIT  = 9'b000000001;
  localparam logic [8:0] c_O_FETCH = 9'b001000000;
  localparam logic [8:0] c_O_INT   = 9'b100000100;

  localparam logic [6:0] c_OPS [11] = '{
    7'b0110111, 7'b0010111, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100111,
    7'b1100011, 7'b0000011, 7'b0100011, 7'b1110011, 7'b1111111
  };

  otter_cu_fsm dut (
    .CLK(CLK), .RST_N(RST_N), .CU_OPCODE(CU_OPCODE), .CU_FUNC3(CU_FUNC3),
    .INTR(INTR), .CSR_MIE(CSR_MIE), .MEM_RDY(MEM_RDY),
    .PC_WRITE(PC_WRITE), .REG_WRITE(REG_WRITE), .MEM_RDEN1(MEM_RDEN1),
    .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2), .CSR_WE(CSR_WE),
    .INT_TAKEN(INT_TAKEN), .MRET_EXEC(MRET_EXEC), .RST_OUT(RST_OUT),
    .CU_STATE(CU_STATE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [8:0] exp_exec(input logic [6:0] opc, input logic [2:0] f3,
                                          input logic rdy);
    case (opc)
      7'b0110111, 7'b0010111, 7'b0110011,
      7'b0010011, 7'b1101111, 7'b1100111: return 9'b110000000;
      7'b1100011: return 9'b100000000;
      7'b0000011: return 9'b100100000;
      7'b0100011: return {rdy, 8'b00010000};
      7'b1110011: return (f3 == 3'b000) ? 9'b100000010 : 9'b110001000;
      default:    return 9'b100000000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [2:0] exp_st, input logic [8:0] exp_o);
    logic [11:0] obs;
    obs = {CU_STATE, PC_WRITE, REG_WRITE, MEM_RDEN1, MEM_RDEN2, MEM_WE2,
           CSR_WE, INT_TAKEN, MRET_EXEC, RST_OUT};
    n_cmp++;
    assert (obs === {exp_st, exp_o}) else begin
      n_err++;
      $error("FAIL %s: observed st=%0d out=%b, expected st=%0d out=%b",
             tag, obs[11:9], obs[8:0], exp_st, exp_o);
    end
  endtask

  // Called at posedge+1: drive this cycle's inputs, check, advance one clock.
  task automatic cyc(input string tag, input logic rdy, input logic intr, input logic mie,
                     input logic [2:0] exp_st, input logic [8:0] exp_o);
    MEM_RDY = rdy;
    INTR    = intr;
    CSR_MIE = mie;
    #2;
    check(tag, exp_st, exp_o);
    @(posedge CLK);
    #1;
  endtask

  task automatic run_instr(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                           input int waits, input logic intr, input logic mie);
    logic r;
    CU_OPCODE = opc;
    CU_FUNC3  = f3;
    cyc({tag, "/fetch"}, 1'($urandom), 1'($urandom), 1'($urandom), 3'd1, c_O_FETCH);
    if (opc == 7'b0100011) begin
      for (int i = 0; i < waits; i++)
        cyc({tag, "/st_stall"}, 1'b0, 1'($urandom), 1'($urandom), 3'd2, exp_exec(opc, f3, 1'b0));
      cyc({tag, "/st_done"}, 1'b1, intr, mie, 3'd2, exp_exec(opc, f3, 1'b1));
    end else if (opc == 7'b0000011) begin
      cyc({tag, "/ld_exec"}, 1'($urandom), 1'($urandom), 1'($urandom), 3'd2,
          exp_exec(opc, f3, 1'b0));
      for (int i = 0; i < waits; i++)
        cyc({tag, "/wb_stall"}, 1'b0, 1'($urandom), 1'($urandom), 3'd3, 9'b0);
      cyc({tag, "/wb_done"}, 1'b1, intr, mie, 3'd3, 9'b010000000);
    end else begin
      r = 1'($urandom);
      cyc({tag, "/exec"}, r, intr, mie, 3'd2, exp_exec(opc, f3, r));
    end
    if (c_INT_EN && intr && mie)
      cyc({tag, "/intr"}, 1'($urandom), 1'($urandom), 1'($urandom), 3'd4, c_O_INT);
  endtask

  initial begin
    int idx;
    logic [2:0] f3;
    RST_N = 1'b0; CU_OPCODE = '0; CU_FUNC3 = '0;
    INTR = 1'b0; CSR_MIE = 1'b0; MEM_RDY = 1'b0;

    // Power-on reset, held across an edge, then released mid-cycle.
    #3 check("reset", 3'd0, c_O_INIT);
    @(posedge CLK); #1;
    check("reset_hold", 3'd0, c_O_INIT);
    #4 RST_N = 1'b1;
    #1 check("reset_release", 3'd0, c_O_INIT);
    @(posedge CLK); #1;

    // Reset asserted in the middle of a store stall.
    CU_OPCODE = 7'b0100011; CU_FUNC3 = 3'b010;
    cyc("rst_st/fetch", 1'b0, 1'b0, 1'b0, 3'd1, c_O_FETCH);
    cyc("rst_st/stall", 1'b0, 1'b1, 1'b1, 3'd2, 9'b000010000);
    MEM_RDY = 1'b0;
    #1 check("rst_st/stall2", 3'd2, 9'b000010000);
    RST_N = 1'b0;
    #1 check("rst_st/async", 3'd0, c_O_INIT);
    #3 RST_N = 1'b1;
    #1 check("rst_st/released", 3'd0, c_O_INIT);
    @(posedge CLK); #1;

    // Directed instruction sequence.
    run_instr("op",       7'b0110011, 3'b000, 0, 1'b0, 1'b0);
    run_instr("load_w2",  7'b0000011, 3'b010, 2, 1'b0, 1'b0);
    run_instr("store_w1", 7'b0100011, 3'b010, 1, 1'b0, 1'b0);
    run_instr("add_int",  7'b0110011, 3'b000, 0, 1'b1, 1'b1);
    run_instr("add_nomie",7'b0110011, 3'b000, 0, 1'b1, 1'b0);
    run_instr("mret",     7'b1110011, 3'b000, 0, 1'b0, 1'b0);
    run_instr("csrrw",    7'b1110011, 3'b001, 0, 1'b0, 1'b0);
    run_instr("mret_int", 7'b1110011, 3'b000, 0, 1'b1, 1'b1);
    run_instr("b2b_int",  7'b1100011, 3'b000, 0, 1'b1, 1'b1);
    run_instr("ld_int",   7'b0000011, 3'b000, 1, 1'b1, 1'b1);
    run_instr("st_int",   7'b0100011, 3'b000, 3, 1'b1, 1'b1);
    run_instr("nop",      7'b1111111, 3'b101, 0, 1'b0, 1'b0);

    // Randomized instruction stream.
    for (int n = 0; n < 80; n++) begin
      idx = $urandom_range(0, 10);
      f3  = 3'($urandom);
      if (c_OPS[idx] == 7'b1110011 && $urandom_range(0, 1) == 0) f3 = 3'b000;
      run_instr("rand", c_OPS[idx], f3, $urandom_range(0, 3),
                1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
